// File: rtl/premcfilter_tml_capture.sv
// Template capture writer: waits for a frame after a request, extracts the
// ROI_SIZE x ROI_SIZE window from the pixel stream and writes it to the
// template buffer as 32-bit words (lowest column in the low byte).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for capture_req
// S_ARMED   | request accepted, waiting for the next frame_begin
// S_CAPTURE | extracting ROI pixels and writing packed words
// S_DONE    | one-cycle completion pulse (err qualifies an abort)
module premcfilter_tml_capture #(
    parameter int ROI_SIZE = 144,
    parameter int WADDR_W  = 13
) (
    input  logic               i_pixclk,
    input  logic               i_reset,
    input  logic [9:0]         i_roi_row_start,
    input  logic [9:0]         i_roi_col_start,
    input  logic               i_capture_req,
    input  logic               i_frame_begin,
    input  logic               i_line_begin,
    input  logic               i_frame_state,
    input  logic               i_line_state,
    input  logic [7:0]         i_sensor_din,
    output logic               o_tml_buf_wren,
    output logic [WADDR_W-1:0] o_tml_buf_wraddr,
    output logic [31:0]        o_tml_buf_wrdata,
    output logic               o_capture_busy,
    output logic               o_capture_done,
    output logic               o_capture_err
);

    localparam int                 NWORDS    = ROI_SIZE * ROI_SIZE / 4;
    localparam logic [WADDR_W-1:0] LAST_ADDR = WADDR_W'(NWORDS - 1);
    localparam logic [9:0]         ROI_LEN   = 10'(ROI_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_err;
    logic                 w_abort;
    logic [9:0]           r_row;
    logic [9:0]           r_col;
    logic                 r_first_line;
    logic [9:0]           r_rs;
    logic [9:0]           r_cs;
    logic [23:0]          r_acc;      // lanes 0..2; lane 3 goes straight to the write word
    logic                 r_wren;
    logic [WADDR_W-1:0]   r_wraddr;
    logic [31:0]          r_wrdata;
    logic [9:0]           w_row_off;
    logic [9:0]           w_col_off;
    logic                 w_in_roi;
    logic                 w_take;
    logic                 w_last_wr;
    logic                 w_start;

    // Offsets are taken relative to the latched start so the window test stays
    // correct even when start+ROI_SIZE would overflow 10 bits.
    assign w_row_off = r_row - r_rs;
    assign w_col_off = r_col - r_cs;
    assign w_in_roi  = (r_row >= r_rs) && (w_row_off < ROI_LEN) &&
                       (r_col >= r_cs) && (w_col_off < ROI_LEN);
    assign w_take    = (r_state == S_CAPTURE) && i_line_state && !i_frame_begin && w_in_roi;
    assign w_last_wr = r_wren && (r_wraddr == LAST_ADDR);
    assign w_start   = (r_state == S_ARMED) && i_frame_begin;

    // State register and abort flag for the done pulse.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_abort;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_abort        = 1'b0;
        o_capture_busy = 1'b0;
        o_capture_done = 1'b0;
        o_capture_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_capture_req) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                o_capture_busy = 1'b1;
                if (i_frame_begin) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                o_capture_busy = 1'b1;
                if (w_last_wr) begin
                    w_state_nxt = S_DONE;
                end else if (i_frame_begin) begin
                    // a new frame before the last word means the ROI ran off the frame
                    w_state_nxt = S_DONE;
                    w_abort     = 1'b1;
                end
            end
            S_DONE: begin
                o_capture_done = 1'b1;
                o_capture_err  = r_err;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line and valid-pixel counters; the first line_begin of a frame is row 0.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            r_row        <= '0;
            r_col        <= '0;
            r_first_line <= 1'b1;
        end else begin
            if (i_frame_begin) begin
                r_row        <= '0;
                r_first_line <= !(i_line_begin && i_frame_state);
            end else if (i_line_begin && i_frame_state) begin
                if (r_first_line) r_first_line <= 1'b0;
                else              r_row        <= r_row + 10'd1;
            end
            r_col <= i_line_state ? (r_col + 10'd1) : 10'd0;
        end
    end

    // ROI origin is frozen at the start of the captured frame.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            r_rs <= '0;
            r_cs <= '0;
        end else if (w_start) begin
            r_rs <= i_roi_row_start;
            r_cs <= i_roi_col_start;
        end
    end

    // Pixel packing, write strobe and word address.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            r_acc    <= '0;
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
        end else begin
            r_wren <= 1'b0;
            if (w_start) begin
                r_acc    <= '0;
                r_wraddr <= '0;
            end else begin
                // hold the final address rather than stepping past the buffer
                if (r_wren && !w_last_wr) r_wraddr <= r_wraddr + 1'b1;
                if (w_take) begin
                    case (w_col_off[1:0])
                        2'd0: r_acc[7:0]   <= i_sensor_din;
                        2'd1: r_acc[15:8]  <= i_sensor_din;
                        2'd2: r_acc[23:16] <= i_sensor_din;
                        2'd3: begin
                            r_wrdata <= {i_sensor_din, r_acc};
                            r_wren   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign o_tml_buf_wren   = r_wren;
    assign o_tml_buf_wraddr = r_wraddr;
    assign o_tml_buf_wrdata = r_wrdata;

endmodule

// File: tb/tb_premcfilter_tml_capture.sv
// Bench for premcfilter_tml_capture: directed frames, table of expected words,
// hand sequences for request/abort/reset/gap corner cases.
module tb_premcfilter_tml_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  roi_rs, roi_cs;
    logic        req, fb, lb, fs, ls;
    logic [7:0]  din;
    logic        wren;
    logic [12:0] wraddr;
    logic [31:0] wrdata;
    logic        busy, done, err;

    always #5 clk = ~clk;

    premcfilter_tml_capture #(.ROI_SIZE(144), .WADDR_W(13)) dut (
        .i_pixclk        (clk),
        .i_reset         (rst),
        .i_roi_row_start (roi_rs),
        .i_roi_col_start (roi_cs),
        .i_capture_req   (req),
        .i_frame_begin   (fb),
        .i_line_begin    (lb),
        .i_frame_state   (fs),
        .i_line_state    (ls),
        .i_sensor_din    (din),
        .o_tml_buf_wren  (wren),
        .o_tml_buf_wraddr(wraddr),
        .o_tml_buf_wrdata(wrdata),
        .o_capture_busy  (busy),
        .o_capture_done  (done),
        .o_capture_err   (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem [0:8191];
    int n_wr, order_bad, exp_addr, n_done, done_err, done_cyc, last_wr_cyc;
    int first_wr_cyc, first_wr_addr, last_fb_cyc;
    int wide_bad = 0, busy_bad = 0, stray_err = 0;
    logic prev_wren = 1'b0;
    logic rst_arm = 1'b0;
    int   rst_at  = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wvec_t;
    wvec_t wtab [7];

    always @(posedge clk) cyc++;

    // Write/done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wren) begin
            if (int'(wraddr) != exp_addr) order_bad++;
            if (n_wr == 0) begin
                first_wr_cyc  = cyc;
                first_wr_addr = int'(wraddr);
            end
            mem[wraddr] = wrdata;
            exp_addr    = int'(wraddr) + 1;
            last_wr_cyc = cyc;
            n_wr++;
            if (prev_wren) wide_bad++;
        end
        prev_wren = wren;
        if (done) begin
            n_done++;
            done_err = int'(err);
            done_cyc = cyc;
            if (busy) busy_bad++;
        end
        if (!done && err) stray_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_wr = 0; order_bad = 0; exp_addr = 0; n_done = 0; done_err = 0;
        done_cyc = -1; last_wr_cyc = -1; first_wr_cyc = -1; first_wr_addr = -1;
        for (int i = 0; i < 7; i++) mem[wtab[i].addr] = 32'hDEADBEEF;
    endtask

    // One input cycle, applied just after the clock edge.
    task automatic drv(input logic f_b, input logic f_s, input logic l_b, input logic l_s,
                       input logic [7:0] d, input logic r_q);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fb = f_b; fs = f_s; lb = l_b; ls = l_s; din = d; req = r_q;
        if (rst_arm && n_wr >= rst_at) begin
            rst     = 1'b1;
            rst_arm = 1'b0;
            #1;
            chk("rst_mid_wren",   32'(wren),   32'd0);
            chk("rst_mid_wraddr", 32'(wraddr), 32'd0);
            chk("rst_mid_wrdata", wrdata,      32'd0);
            chk("rst_mid_busy",   32'(busy),   32'd0);
            chk("rst_mid_done",   32'(done),   32'd0);
            chk("rst_mid_err",    32'(err),    32'd0);
        end
    endtask

    // Frame with pixel = (row+col)&0xFF; req_row=-1 puts the request on frame_begin.
    task automatic run_frame(input int nrows, input int ncols, input int req_row, input int chg_row);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, (req_row == -1));
        last_fb_cyc = cyc;
        for (int r = 0; r < nrows; r++) begin
            if (r == chg_row) begin
                roi_cs = 10'd0;
                roi_rs = 10'd0;
            end
            drv(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, (r == req_row));
            for (int c = 0; c < ncols; c++) drv(1'b0, 1'b1, 1'b0, 1'b1, 8'(r + c), 1'b0);
            drv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_word%0d", tag, wtab[i].addr), mem[wtab[i].addr], wtab[i].data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a3_cyc;
        // expected words for a 154x154 frame with rs=cs=10
        wtab[0] = '{0,    32'h17161514};
        wtab[1] = '{35,   32'hA3A2A1A0};
        wtab[2] = '{36,   32'h18171615};
        wtab[3] = '{100,  32'h89888786};
        wtab[4] = '{2600, 32'h7F7E7D7C};
        wtab[5] = '{4000, 32'h96959493};
        wtab[6] = '{5183, 32'h3231302F};

        rst = 1'b1; req = 0; fb = 0; lb = 0; fs = 0; ls = 0; din = '0;
        roi_rs = 10'd10; roi_cs = 10'd10;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_wren",   32'(wren),   32'd0);
        chk("reset_wraddr", 32'(wraddr), 32'd0);
        chk("reset_wrdata", wrdata,      32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_err",    32'(err),    32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // request in the middle of a frame: that frame is skipped
        clear_mon();
        run_frame(6, 154, 3, -99);
        chk("midreq_no_writes", n_wr, 0);
        chk("midreq_busy", 32'(busy), 32'd1);
        run_frame(154, 154, -99, -99);
        chk("basic_count", n_wr, 5184);
        chk("basic_order", order_bad, 0);
        check_table("basic");
        chk("basic_done_cnt", n_done, 1);
        chk("basic_err", done_err, 0);
        chk("basic_done_lat", done_cyc - last_wr_cyc, 1);
        chk("basic_busy_after", 32'(busy), 32'd0);

        // request on frame_begin waits a full frame; second request and roi change ignored
        clear_mon();
        run_frame(6, 154, -1, -99);
        chk("coinc_no_writes", n_wr, 0);
        chk("coinc_busy", 32'(busy), 32'd1);
        run_frame(154, 154, 50, 50);
        chk("redund_count", n_wr, 5184);
        chk("redund_order", order_bad, 0);
        check_table("redund");
        chk("redund_done_cnt", n_done, 1);
        chk("redund_err", done_err, 0);

        // reset after 1000 writes
        roi_rs = 10'd0; roi_cs = 10'd0;
        clear_mon();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        chk("busy_before_accept", 32'(busy), 32'd0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        rst_at = 1000; rst_arm = 1'b1;
        run_frame(30, 154, -99, -99);
        chk("rst_fired", 32'(rst_arm), 32'd0);
        chk("rst_no_more_writes", n_wr, 1000);
        chk("rst_busy_after", 32'(busy), 32'd0);
        chk("rst_no_done", n_done, 0);

        // line_state gap inside the ROI; new request restarts addressing at 0
        clear_mon();
        mem[1] = 32'hDEADBEEF; mem[36] = 32'hDEADBEEF;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        a3_cyc = -100;
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
            if (i == 3) a3_cyc = cyc;
        end
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int c = 0; c < 144; c++) drv(1'b0, 1'b1, 1'b0, 1'b1, 8'(c), 1'b0);
        repeat (3) drv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        chk("gap_count", n_wr, 37);
        chk("gap_first_addr", first_wr_addr, 0);
        chk("gap_order", order_bad, 0);
        chk("gap_word0", mem[0], 32'hA3A2A1A0);
        chk("gap_word1", mem[1], 32'h03020100);
        chk("gap_word36", mem[36], 32'h8F8E8D8C);
        chk("gap_wren_lat", first_wr_cyc - a3_cyc, 1);

        // next frame_begin aborts the unfinished capture
        run_frame(2, 144, -99, -99);
        chk("gap_abort_done", n_done, 1);
        chk("gap_abort_err", done_err, 1);
        chk("gap_abort_lat", done_cyc - last_fb_cyc, 1);
        chk("gap_abort_no_writes", n_wr, 37);

        // ROI runs past the bottom of a 150-row frame
        roi_rs = 10'd10; roi_cs = 10'd0;
        clear_mon();
        mem[5039] = 32'hDEADBEEF;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        run_frame(150, 144, -99, -99);
        chk("edge_count", n_wr, 5040);
        chk("edge_order", order_bad, 0);
        chk("edge_no_done_yet", n_done, 0);
        chk("edge_word0", mem[0], 32'h0D0C0B0A);
        chk("edge_word5039", mem[5039], 32'h24232221);
        run_frame(4, 144, -99, -99);
        chk("edge_done", n_done, 1);
        chk("edge_err", done_err, 1);
        chk("edge_done_lat", done_cyc - last_fb_cyc, 1);
        chk("edge_writes_stop", n_wr, 5040);

        chk("wren_one_cycle", wide_bad, 0);
        chk("busy_low_at_done", busy_bad, 0);
        chk("err_only_with_done", stray_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
